// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall/flush controller with a held-over branch flush,
// a saturating stall-cycle counter and a sticky runaway-stall watchdog.
module pipe_stall_ctrl #(
  parameter int NSTAGE     = 5,
  parameter int BR_STAGE   = 2,
  parameter int CNT_W      = 32,
  parameter int WDOG_LIMIT = 4095
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NSTAGE-1:0]     stall_req,
  input  logic                  flush_req,
  output logic [2*NSTAGE-1:0]   stall_sign,
  output logic [NSTAGE-2:0]     flush_sign,
  output logic [CNT_W-1:0]      stall_cycles,
  output logic                  wdog_err
);

  localparam int SW = 2 * NSTAGE;
  localparam int FW = NSTAGE - 1;
  localparam int WW = $clog2(WDOG_LIMIT + 1);

  localparam logic [FW-1:0] FL_MASK =
    {{(FW - BR_STAGE){1'b0}}, {BR_STAGE{1'b1}}};
  localparam logic [SW-1:0] UP_MASK =
    {{(SW - 2*BR_STAGE){1'b0}}, {(2*BR_STAGE){1'b1}}};
  localparam logic [WW-1:0] WLIM = WW'(WDOG_LIMIT);
  localparam logic [WW-1:0] WPRE = WW'(WDOG_LIMIT - 1);

  logic [SW-1:0]    stall_raw;
  logic [SW-1:0]    stall_fin;
  logic [FW-1:0]    flush_fin;
  logic             flush_pend;
  logic             eff_flush;
  logic             down_stall;
  logic             blocked;
  logic             flush_go;
  logic             is_stall;
  logic [WW-1:0]    wcnt;

  // Union of per-requester masks == ones up to the highest requester.
  always_comb begin
    stall_raw = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (stall_req[i]) begin
        for (int j = 0; j <= 2*i; j++) begin
          stall_raw[j] = 1'b1;
        end
      end
    end
  end

  assign down_stall = |stall_req[NSTAGE-1:BR_STAGE+1];
  assign eff_flush  = flush_req | flush_pend;
  assign blocked    = eff_flush & down_stall;
  assign flush_go   = eff_flush & ~down_stall;

  always_comb begin
    stall_fin = stall_raw;
    flush_fin = '0;
    if (flush_go) begin
      stall_fin = stall_raw & ~UP_MASK;
      flush_fin = FL_MASK;
    end
  end

  assign stall_sign = rst ? stall_fin : '0;
  assign flush_sign = rst ? flush_fin : '0;
  assign is_stall   = |stall_fin;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flush_pend <= 1'b0;
    end else begin
      flush_pend <= blocked;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
    end else if (is_stall && stall_cycles != '1) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

  // Watchdog run length saturates at the limit; the error is sticky.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt     <= '0;
      wdog_err <= 1'b0;
    end else if (is_stall) begin
      if (wcnt != WLIM) begin
        wcnt <= wcnt + WW'(1);
      end
      if (wcnt == WPRE) begin
        wdog_err <= 1'b1;
      end
    end else begin
      wcnt <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: rule-level reference model checked every
// cycle plus directed literal expectations.
module tb_pipe_stall_ctrl;

  localparam int NS  = 5;
  localparam int BR  = 2;
  localparam int CW  = 4;
  localparam int WL  = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NS-1:0] stall_req = '0;
  logic          flush_req = 1'b0;
  logic [2*NS-1:0] stall_sign;
  logic [NS-2:0]   flush_sign;
  logic [CW-1:0]   stall_cycles;
  logic            wdog_err;

  int n_pass = 0;
  int n_total = 0;

  pipe_stall_ctrl #(
    .NSTAGE(NS), .BR_STAGE(BR), .CNT_W(CW), .WDOG_LIMIT(WL)
  ) dut (
    .clk(clk), .rst(rst),
    .stall_req(stall_req), .flush_req(flush_req),
    .stall_sign(stall_sign), .flush_sign(flush_sign),
    .stall_cycles(stall_cycles), .wdog_err(wdog_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp,
                  $time);
  endtask

  // Reference model: abstract state (pending flush, counts, run length).
  bit m_pend;
  int m_cycles;
  int m_run;
  bit m_err;

  always @(negedge clk) begin
    int k;
    int es;
    int ef;
    bit eff;
    bit blk;
    if (!rst) begin
      m_pend = 0; m_cycles = 0; m_run = 0; m_err = 0;
      check("m_rst_stall", 32'(stall_sign), 0);
      check("m_rst_flush", 32'(flush_sign), 0);
      check("m_rst_cycles", 32'(stall_cycles), 0);
      check("m_rst_wdog", 32'(wdog_err), 0);
    end else begin
      k = -1;
      for (int i = 0; i < NS; i++) if (stall_req[i]) k = i;
      es = (k >= 0) ? (1 << (2*k + 1)) - 1 : 0;
      ef = 0;
      eff = flush_req || m_pend;
      blk = eff && (k > BR);
      if (eff && !blk) begin
        ef = (1 << BR) - 1;
        es = es & ~((1 << (2*BR)) - 1);
      end
      check("m_stall_sign", 32'(stall_sign), es);
      check("m_flush_sign", 32'(flush_sign), ef);
      check("m_stall_cycles", 32'(stall_cycles), m_cycles);
      check("m_wdog_err", 32'(wdog_err), 32'(m_err));
      m_pend = blk;
      if (es != 0) begin
        if (m_cycles < (1 << CW) - 1) m_cycles++;
        m_run++;
        if (m_run >= WL) m_err = 1;
      end else begin
        m_run = 0;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) cyc();
    #1;
    check("rst_stall", 32'(stall_sign), 0);
    check("rst_cycles", 32'(stall_cycles), 0);
    cyc(); rst = 1'b1;
    cyc(); stall_req = 5'b00010; #1;
    check("s1_sign", 32'(stall_sign), 32'b0000000111);
    check("s1_flush", 32'(flush_sign), 0);
    check("s1_cyc0", 32'(stall_cycles), 0);
    cyc(); #1;
    check("s1_cyc1", 32'(stall_cycles), 1);
    cyc(); stall_req = '0; #1;
    check("s1_cyc2", 32'(stall_cycles), 2);
    cyc(); stall_req = 5'b01010; #1;
    check("s3_wins", 32'(stall_sign), 32'b0001111111);
    check("s3_flush", 32'(flush_sign), 0);
    cyc(); stall_req = '0; #1;
    check("s3_cyc", 32'(stall_cycles), 3);
    cyc(); flush_req = 1'b1; #1;
    check("fl_sign", 32'(flush_sign), 32'b0011);
    check("fl_stall", 32'(stall_sign), 0);
    cyc(); flush_req = 1'b0; #1;
    check("fl_after", 32'(flush_sign), 0);
    // Flush held under a downstream stall, with a second merged request.
    cyc(); stall_req = 5'b01000; flush_req = 1'b1; #1;
    check("hold_c1", 32'(flush_sign), 0);
    cyc(); flush_req = 1'b0; #1;
    check("hold_c2", 32'(flush_sign), 0);
    cyc(); flush_req = 1'b1; #1;
    check("hold_c3", 32'(flush_sign), 0);
    cyc(); stall_req = '0; flush_req = 1'b0; #1;
    check("hold_c4", 32'(flush_sign), 32'b0011);
    cyc(); #1;
    check("hold_c5", 32'(flush_sign), 0);
    cyc(); stall_req = 5'b00010; flush_req = 1'b1; #1;
    check("ovr_flush", 32'(flush_sign), 32'b0011);
    check("ovr_stall", 32'(stall_sign), 0);
    cyc(); stall_req = 5'b00100; #1;
    check("br_flush", 32'(flush_sign), 32'b0011);
    check("br_stall", 32'(stall_sign), 32'b0000010000);
    cyc(); stall_req = '0; flush_req = 1'b0;
    cyc(); rst = 1'b0;
    cyc(); rst = 1'b1;
    cyc(); stall_req = 5'b00001;
    for (int i = 1; i <= 4; i++) begin
      cyc(); #1;
      check("wdog_run", 32'(wdog_err), (i == 4) ? 1 : 0);
    end
    stall_req = '0;
    repeat (2) cyc();
    #1;
    check("wdog_sticky", 32'(wdog_err), 1);
    stall_req = 5'b10000;
    repeat (14) cyc();
    #1;
    check("cyc_sat", 32'(stall_cycles), 15);
    flush_req = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    check("mid_stall", 32'(stall_sign), 0);
    check("mid_flush", 32'(flush_sign), 0);
    check("mid_cycles", 32'(stall_cycles), 0);
    check("mid_wdog", 32'(wdog_err), 0);
    cyc();
    stall_req = '0; flush_req = 1'b0;
    cyc(); rst = 1'b1;
    repeat (2) cyc();
    #1;
    check("post_rst_cycles", 32'(stall_cycles), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
